// File: rtl/instr_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// default instruction-memory depth.
package instr_loader_pkg;

  localparam int DEFAULT_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/instr_loader.sv
// Streams little-endian program bytes into 32-bit words and writes them to the
// instruction memory, holding the CPU off until the whole image is stored.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_start,
  input  logic [LW-1:0] load_len,
  input  logic [7:0]    byte_data,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          store_en,
  output logic [AW-1:0] store_address,
  output logic [31:0]   store_data,
  output logic          cpu_hold,
  output logic          load_done,
  output logic [7:0]    checksum
);

  state_t        state, state_next;
  logic [LW-1:0] len_reg;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_buf;
  logic [LW-1:0] len_clamped;
  logic          last_word;
  logic          take_byte;

  assign len_clamped = (load_len > LW'(DEPTH)) ? LW'(DEPTH) : load_len;
  assign last_word   = ({1'b0, word_idx} == (len_reg - LW'(1)));
  assign take_byte   = (state == COLLECT) && byte_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    store_en   = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_next = (load_len == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        store_en   = 1'b1;
        cpu_hold   = 1'b1;
        state_next = last_word ? DONE : COLLECT;
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The store registers are loaded on the 4th byte so they present the word
  // during WRITE and keep it afterwards until the next word completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_reg       <= '0;
      word_idx      <= '0;
      byte_cnt      <= '0;
      word_buf      <= '0;
      store_address <= '0;
      store_data    <= '0;
      checksum      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            len_reg  <= len_clamped;
            word_idx <= '0;
            byte_cnt <= '0;
            checksum <= '0;
          end
        end
        COLLECT: begin
          if (take_byte) begin
            checksum <= checksum ^ byte_data;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                store_data    <= {byte_data, word_buf};
                store_address <= word_idx;
              end
            endcase
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          if (!last_word) begin
            word_idx <= word_idx + AW'(1);
          end
          byte_cnt <= '0;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in the target instruction memory; address width is $clog2(DEPTH) = 6.
REQ-002 clk  input  1  single clock for all state; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 load_start  input  1  one-cycle request to begin a program load; honoured only in IDLE.
REQ-005 load_len  input  7  number of words to load, sampled with load_start; range 0..64.
REQ-006 byte_data  input  8  program byte stream, little-endian within each word.
REQ-007 byte_valid  input  1  byte_data is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
REQ-009 store_en  output  1  write strobe to the instruction memory, one cycle per word.
REQ-010 store_address  output  6  word address for the write.
REQ-011 store_data  output  32  assembled word for the write.
REQ-012 cpu_hold  output  1  high while a load is in progress; the core must not fetch while it is high.
REQ-013 load_done  output  1  one-cycle pulse when the final word has been written.
REQ-014 checksum  output  8  XOR of all bytes accepted in the current or last load.

Function
REQ-015 The FSM SHALL have four states: IDLE, COLLECT, WRITE, DONE.
REQ-016 IDLE: load_start=1 with load_len>0 -> COLLECT; word index=0, byte count=0, checksum=0, cpu_hold=1 from the next cycle.
REQ-017 IDLE: load_start=1 with load_len=0 -> DONE directly; no writes, checksum cleared to 0.
REQ-018 load_len>DEPTH SHALL be clamped to DEPTH.
REQ-019 byte_ready SHALL be 1 only in COLLECT; byte_valid in any other state is ignored and the byte is not consumed.
REQ-020 Each accepted byte SHALL go into bits [8*k+7:8*k] of the word buffer, k = byte count 0..3, and SHALL be XORed into checksum.
REQ-021 Acceptance of the 4th byte SHALL move the FSM to WRITE; byte_ready SHALL be 0 in WRITE.
REQ-022 WRITE lasts exactly one cycle: store_en=1, store_address=word index, store_data=assembled word.
REQ-023 store_en SHALL be 0 in every state other than WRITE; store_address/store_data hold their last values when store_en=0.
REQ-024 From WRITE: if word index = len-1 -> DONE; else word index +1, byte count 0, -> COLLECT.
REQ-025 DONE lasts one cycle: load_done=1, cpu_hold=0 during it, next state IDLE.
REQ-026 Latency: the write of a word occurs on the cycle after its 4th byte is accepted; load_done follows the last write by one cycle.
REQ-027 load_start outside IDLE SHALL be ignored and SHALL NOT alter load_len or progress.
REQ-028 Byte gaps (byte_valid=0) of any length SHALL stall COLLECT without losing partial-word state.
REQ-029 checksum SHALL hold its value after DONE until the next accepted load_start.
REQ-030 Word index SHALL never exceed DEPTH-1; no address wrap within one load.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE and set byte_ready=0, store_en=0, store_address=0, store_data=0, cpu_hold=0, load_done=0, checksum=0, word index=0, byte count=0.
REQ-032 Reset mid-load SHALL abandon the load with no further writes; words already written remain in the instruction memory.

Structure
REQ-033 The state enum and the DEPTH default constant SHALL live in shared package instr_loader_pkg.
REQ-034 The block SHALL be a single module; no sub-module is required.

Verification
REQ-035 load_start, load_len=1, bytes 0x78,0x56,0x34,0x12 back-to-back -> one store_en with address 0, data 0x12345678; load_done on the next cycle; checksum=0x08.
REQ-036 load_len=3, 12 bytes with random byte_valid gaps -> writes to addresses 0,1,2 in order, each one cycle after its 4th byte, cpu_hold high until DONE.
REQ-037 load_len=0 -> no store_en, load_done pulse on the cycle after load_start, checksum=0.
REQ-038 load_len=100 -> exactly 64 writes at addresses 0..63, then load_done.
REQ-039 load_start pulsed during COLLECT of a 2-word load -> ignored; exactly 2 writes occur.
REQ-040 reset_n low after 6 bytes of a 2-word load -> address 0 already written, no second write, all outputs at reset values, a new load_start is accepted normally.
